// File: rtl/abacus_sample_controller.sv
`default_nettype none
// ============================================================================
// Module      : abacus_sample_controller
// Description : Sequencer that runs the ABACUS profiling units in timed
//               measurement windows. It gates the profiler enables, clears the
//               profiler counters at window start, lets in-flight counter
//               updates drain at window end, strobes a snapshot capture into
//               the shadow registers and raises a sticky per-window interrupt.
//
// Parameters  : WINDOW_W     - width of window length / elapsed-cycle counter
//               DRAIN_CYCLES - cycles spent in SNAP before capture (>= 1)
//               DONE_CNT_W   - width of the saturating completed-window count
//
// Build option: ABACUS_TRIGGER_EN - when defined, a start or auto restart
//               waits in ARMED until an issued instruction equals
//               cfg_trigger_instr. When undefined, cfg_trigger_instr,
//               instruction_issued and issued_instruction are unused and
//               start/restart go straight to RUN.
//
// Ports       : clk, rst (synchronous, active-high)
//               cmd_start / cmd_stop / cmd_clear  - one-cycle command pulses
//               cfg_window_len   - window length in cycles, 0 = unbounded
//               cfg_auto_restart - start the next window after each capture
//               instruction_issued, issued_instruction, cfg_trigger_instr
//                                - trigger inputs
//               irq_ack          - clears irq
//               prof_enable      - enable to all profiler units
//               counter_clear    - one-cycle clear pulse to profiler counters
//               snapshot_capture - one-cycle shadow-register capture strobe
//               irq              - sticky window-complete interrupt
//               state            - IDLE=0 ARMED=1 RUN=2 SNAP=3 DONE=4
//               window_count     - elapsed cycles in the current window
//               windows_done     - number of completed windows (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module abacus_sample_controller #(
    parameter int WINDOW_W     = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int DONE_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic                  cmd_clear,
    input  logic [WINDOW_W-1:0]   cfg_window_len,
    input  logic                  cfg_auto_restart,
    input  logic                  instruction_issued,
    input  logic [31:0]           issued_instruction,
    input  logic [31:0]           cfg_trigger_instr,
    input  logic                  irq_ack,
    output logic                  prof_enable,
    output logic                  counter_clear,
    output logic                  snapshot_capture,
    output logic                  irq,
    output logic [2:0]            state,
    output logic [WINDOW_W-1:0]   window_count,
    output logic [DONE_CNT_W-1:0] windows_done
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_ARMED = 3'd1;
    localparam logic [2:0] c_ST_RUN   = 3'd2;
    localparam logic [2:0] c_ST_SNAP  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    // Drain counter needs at least one bit even when DRAIN_CYCLES is 1.
    localparam int c_DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_ONE  = c_DRAIN_W'(1);
    // With a single drain cycle the capture strobe must already be raised
    // on the RUN -> SNAP transition.
    localparam logic c_CAPTURE_ON_ENTRY = (DRAIN_CYCLES == 1);

`ifdef ABACUS_TRIGGER_EN
    localparam logic [2:0] c_START_STATE = c_ST_ARMED;
    localparam logic       c_START_EN    = 1'b0;
    logic w_trigger;
    assign w_trigger = instruction_issued && (issued_instruction == cfg_trigger_instr);
`else
    localparam logic [2:0] c_START_STATE = c_ST_RUN;
    localparam logic       c_START_EN    = 1'b1;
    logic w_trigger;
    assign w_trigger = 1'b0;
    // Trigger inputs have no function in this build.
    logic w_unused_trigger;
    assign w_unused_trigger = ^{instruction_issued, issued_instruction, cfg_trigger_instr};
`endif

    logic [2:0]            r_state;
    logic                  r_prof_enable;
    logic                  r_counter_clear;
    logic                  r_snapshot_capture;
    logic                  r_irq;
    logic [WINDOW_W-1:0]   r_window_count;
    logic [DONE_CNT_W-1:0] r_windows_done;
    logic                  r_stop_pending;
    logic [c_DRAIN_W-1:0]  r_drain;

    logic                  w_len_hit;
    logic                  w_capture;
    logic                  w_restart;
    logic [WINDOW_W-1:0]   w_len_m1;
    logic [DONE_CNT_W-1:0] w_done_next;

    // Equality against len-1 (rather than >=) means a length shrunk below
    // the running count only ends the window after the counter wraps.
    assign w_len_m1   = cfg_window_len - WINDOW_W'(1);
    assign w_len_hit  = (cfg_window_len != '0) && (r_window_count == w_len_m1);
    assign w_capture  = (r_state == c_ST_SNAP) && (r_drain == c_DRAIN_LAST);
    // A stop arriving in the final SNAP cycle also suppresses the restart.
    assign w_restart  = cfg_auto_restart && !r_stop_pending && !cmd_stop;
    assign w_done_next = (&r_windows_done) ? r_windows_done
                                           : r_windows_done + DONE_CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= c_ST_IDLE;
            r_prof_enable      <= 1'b0;
            r_counter_clear    <= 1'b0;
            r_snapshot_capture <= 1'b0;
            r_irq              <= 1'b0;
            r_window_count     <= '0;
            r_windows_done     <= '0;
            r_stop_pending     <= 1'b0;
            r_drain            <= '0;
        end else begin
            r_counter_clear    <= 1'b0;
            r_snapshot_capture <= 1'b0;

            // Capture sets irq and takes priority over a coincident ack.
            if (w_capture) begin
                r_irq <= 1'b1;
            end else if (irq_ack) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    r_prof_enable <= 1'b0;
                    if (cmd_clear) begin
                        r_windows_done <= '0;
                    end
                    if (cmd_start) begin
                        r_counter_clear <= 1'b1;
                        r_window_count  <= '0;
                        r_stop_pending  <= 1'b0;
                        r_state         <= c_START_STATE;
                        r_prof_enable   <= c_START_EN;
                    end else if (cmd_clear) begin
                        r_counter_clear <= 1'b1;
                    end
                end

                c_ST_ARMED: begin
                    r_prof_enable <= 1'b0;
                    if (cmd_stop) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_trigger) begin
                        r_state       <= c_ST_RUN;
                        r_prof_enable <= 1'b1;
                    end
                end

                c_ST_RUN: begin
                    r_prof_enable <= 1'b1;
                    if (cmd_clear) begin
                        r_counter_clear <= 1'b1;
                        r_window_count  <= '0;
                    end else begin
                        r_window_count <= r_window_count + WINDOW_W'(1);
                    end
                    if (cmd_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (cmd_stop || w_len_hit) begin
                        r_state            <= c_ST_SNAP;
                        r_prof_enable      <= 1'b0;
                        r_drain            <= '0;
                        r_snapshot_capture <= c_CAPTURE_ON_ENTRY;
                    end
                end

                c_ST_SNAP: begin
                    r_prof_enable <= 1'b0;
                    if (cmd_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (w_capture) begin
                        r_windows_done <= w_done_next;
                        r_drain        <= '0;
                        if (w_restart) begin
                            r_counter_clear <= 1'b1;
                            r_window_count  <= '0;
                            r_stop_pending  <= 1'b0;
                            r_state         <= c_START_STATE;
                            r_prof_enable   <= c_START_EN;
                        end else begin
                            r_state <= c_ST_DONE;
                        end
                    end else begin
                        r_drain <= r_drain + c_DRAIN_ONE;
                        // Raise the strobe so it is visible in the last SNAP cycle.
                        r_snapshot_capture <= ((r_drain + c_DRAIN_ONE) == c_DRAIN_LAST);
                    end
                end

                default: begin
                    r_state       <= c_ST_IDLE;
                    r_prof_enable <= 1'b0;
                end
            endcase
        end
    end

    assign prof_enable      = r_prof_enable;
    assign counter_clear    = r_counter_clear;
    assign snapshot_capture = r_snapshot_capture;
    assign irq              = r_irq;
    assign state            = r_state;
    assign window_count     = r_window_count;
    assign windows_done     = r_windows_done;

endmodule
`default_nettype wire
